// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among writeback requesters.
// Grants one requester per cycle and drives the bank write port from a registered stage.
module regbank_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*REG_W-1:0]    req_reg,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_grant,
  output logic                     regWrite,
  output logic [REG_W-1:0]         writeReg,
  output logic [DATA_W-1:0]        writeData,
  output logic                     wb_busy
);

  localparam int unsigned LAST_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LAST_W-1:0] LAST_RST = LAST_W'(NREQ - 1);

  logic [LAST_W-1:0] last_q, last_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_W-1:0]  writereg_q, writereg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;

  logic [NREQ-1:0]   grant_c;
  logic              found_c;
  logic [REG_W-1:0]  win_reg_c;
  logic [DATA_W-1:0] win_data_c;

  logic [REG_W-1:0]  reg_a  [NREQ];
  logic [DATA_W-1:0] data_a [NREQ];

  // Unpack the flat request buses into per-requester slices.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign reg_a[g]  = req_reg[g*REG_W +: REG_W];
    assign data_a[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Search from last+1 upward, wrapping; first valid requester wins.
  always_comb begin : arb_comb
    int unsigned        base;
    logic [LAST_W-1:0]  idx;
    grant_c    = '0;
    found_c    = 1'b0;
    win_reg_c  = '0;
    win_data_c = '0;
    last_d     = last_q;
    base       = 32'(last_q);
    idx        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = LAST_W'((base + k) % NREQ);
      if (!found_c && !rst && req_valid[idx]) begin
        found_c      = 1'b1;
        grant_c[idx] = 1'b1;
        win_reg_c    = reg_a[idx];
        win_data_c   = data_a[idx];
        last_d       = idx;
      end
    end
  end

  // Writes to register 0 complete the handshake but never enable the bank.
  always_comb begin : out_comb
    regwrite_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (found_c) begin
      regwrite_d  = (win_reg_c != '0);
      writereg_d  = win_reg_c;
      writedata_d = win_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= LAST_RST;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      last_q      <= last_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  assign req_grant = grant_c;
  assign wb_busy   = !rst && (|(req_valid & ~grant_c));
  assign regWrite  = regwrite_q;
  assign writeReg  = writereg_q;
  assign writeData = writedata_q;

endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Shares the single write port of the register bank (`regWrite`/`writeReg`/`writeData`) among several writeback requesters: ALU result, load data and call/link unit. It grants one requester per cycle by round-robin and drives the bank write port from a registered stage. It sits between the execute/memory stages and the register bank.

## Interface
Parameters:
- `NREQ`, 3: number of requesters. Index 0 = ALU, 1 = load, 2 = link.
- `DATA_W`, 32: write data width.
- `REG_W`, 5: register index width.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `req_valid`  in  NREQ  bit i = requester i has a pending write.
- `req_reg`  in  NREQ*REG_W  slice i = destination register of requester i.
- `req_data`  in  NREQ*DATA_W  slice i = write data of requester i.
- `req_grant`  out  NREQ  one-hot, combinational; bit i = requester i accepted this cycle.
- `regWrite`  out  1  bank write enable (registered).
- `writeReg`  out  REG_W  bank write index (registered).
- `writeData`  out  DATA_W  bank write data (registered).
- `wb_busy`  out  1  combinational; high when any `req_valid` bit is high but not granted this cycle.

## Operation
- Handshake: a requester raises `req_valid[i]` and holds `req_reg`/`req_data` stable until `req_grant[i]` is high. Its transfer completes in the cycle `req_valid[i] & req_grant[i]`. It may drop or change the request in the following cycle.
- `req_grant` is one-hot or zero. It is zero whenever `rst` is high or no `req_valid` bit is set. `req_grant[i]` never asserts without `req_valid[i]`.
- Round-robin state `last` (index of the most recent grant, width clog2(NREQ)):
  - Search order is `last+1, last+2, …` modulo NREQ, wrapping from NREQ-1 to 0.
  - The first valid requester in that order wins.
  - `last` updates to the winner only on a grant. It holds when there is no grant.
- Output stage:
  - On a grant, the next edge loads `writeReg`/`writeData` from the winner's slices and sets `regWrite`.
  - With no grant, `regWrite` clears at the next edge. `writeReg`/`writeData` hold their last values.
- Register 0 suppression: a grant with destination 0 completes the handshake normally, but `regWrite` stays 0 in the following cycle. `writeReg`/`writeData` still load the granted values.
- Same destination register: requests to the same register in the same cycle are not merged. They are granted one per cycle in round-robin order, so the bank ends with the value of the later grant.
- There is no internal queue; backpressure happens only by withholding grant.

## Timing
- Reset values:
  - `last` = NREQ-1, so requester 0 has top priority after reset.
  - `regWrite` = 0, `writeReg` = 0, `writeData` = 0.
  - `req_grant` = 0 and `wb_busy` = 0 while `rst` is high.
- Latency: grant in cycle N; the bank write port is driven during cycle N+1 and the bank samples it at the end of N+1. A read of that register in cycle N+2 returns the new value.
- Throughput: one write per cycle with back-to-back grants. Under continuous contention each requester waits at most NREQ-1 cycles.
- Reset mid-operation:
  - `rst` high in cycle N (including a cycle with valid requests) gives no grant in N.
  - Any write registered for N+1 is cancelled: `regWrite` is 0 after the reset edge.
  - Requests still pending after `rst` falls are arbitrated from `last` = NREQ-1.
- `wb_busy` is purely combinational from `req_valid` and `req_grant`.

## Test plan
- Single request: release reset; `req_valid`=3'b001, reg 4, data 32'hAABBCCDD.
  - Required: `req_grant`=3'b001 in the same cycle.
  - Next cycle: `regWrite`=1, `writeReg`=4, `writeData`=32'hAABBCCDD.
  - Two cycles later: bank `rs`=4 reads 32'hAABBCCDD.
- Three-way contention right after reset: all valid with regs 4, 5, 31.
  - Required grants over consecutive cycles: 001, 010, 100.
  - Required bank writes in the following cycles: 4, 5, 31.
  - `wb_busy` = 1, 1, 0 across those three cycles.
- Fairness: requesters 0 and 1 held valid continuously for 8 cycles.
  - Required: grants alternate 001/010, 4 each.
  - `regWrite` stays high for 8 consecutive cycles.
- Register 0: request to reg 0 with data 32'h12345678.
  - Required: grant asserted; next cycle `regWrite`=0.
  - Bank register 0 unchanged.
- Same register: requesters 1 and 2 both target reg 5 (data 32'h1111_1111 and 32'h2222_2222) with `last`=0.
  - Required: requester 1 granted first, then requester 2.
  - Final bank reg 5 = 32'h2222_2222.
- Reset mid-operation: assert `rst` in the cycle requester 2 would be granted.
  - Required: `req_grant`=0 in that cycle and `regWrite`=0 in the next.
  - After `rst` falls, with requesters 0 and 2 still valid, requester 0 is granted first.
